video_shifter: RTL and testbench
================================

# video_shifter

Pixel serializer sitting directly downstream of the Mac Plus video timer. Captures each 16-bit framebuffer word fetched while the timer's `loadPixels` is asserted, holds it in a one-word buffer, and shifts it out MSB-first at one pixel per pixel tick. Delays the timer's sync and blank signals by a matching number of ticks so that pixels, syncs and data-enable leave the block aligned.

## Interface
Parameters:
- `SYNC_DELAY`, 16: pixel ticks of delay applied to hsync, vsync and the active flag. Legal range is 1..32. 16 matches the one-word fetch-to-display latency.
- `INVERT`, 1: when 1, `video = ~pixel bit`. Mac framebuffer 1 = black, so output 1 = lit.

Ports:
- `clk`  in  1  system clock, the same clock as the video timer.
- `_reset`  in  1  asynchronous, active-low reset.
- `clk8_en_p`  in  1  pixel-tick enable, phase p.
- `clk8_en_n`  in  1  pixel-tick enable, phase n.
- `loadPixels`  in  1  `dataIn` is valid framebuffer data on this tick.
- `dataIn`  in  16  framebuffer word. Bit 15 is the leftmost pixel.
- `_hblank`  in  1  active-low horizontal blank from the timer.
- `_vblank`  in  1  active-low vertical blank from the timer.
- `hsync`  in  1  active-low hsync from the timer.
- `vsync`  in  1  active-low vsync from the timer.
- `underrun_clr`  in  1  clears the sticky `underrun` flag.
- `video`  out  1  serialized pixel, forced to 0 outside the active area.
- `hsync_out`  out  1  hsync delayed by `SYNC_DELAY` ticks.
- `vsync_out`  out  1  vsync delayed by `SYNC_DELAY` ticks.
- `de_out`  out  1  active flag delayed by `SYNC_DELAY` ticks.
- `underrun`  out  1  sticky: a word boundary found no buffered word.

## Operation
- Tick definition: tick = rising `clk` with `clk8_en_p | clk8_en_n`. All state changes on ticks, except reset and `underrun_clr`.
- Active flag: `act = _hblank & _vblank`. `act_d` is `act` registered at the previous tick.
- Phase counter `cnt[3:0]`, updated per tick:
  - `act & ~act_d`: `cnt <= 1`. The rising tick counts as phase 0.
  - `act & act_d`: `cnt <= cnt + 1`, wrapping at 15 → 0.
  - `~act`: `cnt <= 0`.
  - Word boundary = tick with `act` true and phase 15. The phase is `cnt`, or 0 on a rising tick.
- Hold buffer, per tick:
  - `loadPixels` = 1: `hold <= dataIn`, `hold_v <= 1`. Last load before the boundary wins.
  - Word boundary: `shreg <= hold_v ? hold : 16'h0000`, and `hold_v <= 0`.
  - If `hold_v` = 0 at a boundary, set `underrun`.
  - Load coincident with a boundary: `shreg` takes the old `hold`. The new data then lands in `hold` with `hold_v` = 1, and `underrun` evaluates the old `hold_v`.
- Shifter: on every non-boundary tick, `shreg <= {shreg[14:0], 1'b0}`. Shifting continues through blanking, so the last word of a line drains after `act` falls.
- Delay lines: `SYNC_DELAY`-deep tick-enabled shift registers carry `hsync`, `vsync` and `act`.
- `video = de_out ? (shreg[15] ^ INVERT) : 0`. This is a combinational output from registers.
- `underrun` is set by the boundary condition above and cleared on any `clk` with `underrun_clr` = 1. If set and clear occur on the same cycle, set wins.

## Timing
- Reset (async assert, sync-free): `shreg`, `hold`, `hold_v`, `cnt`, `act_d` and `underrun` all 0. The hsync and vsync delay stages go to 1; the `act` delay stage goes to 0.
- Outputs during reset: `video` = 0, `hsync_out` = `vsync_out` = 1, `de_out` = 0, `underrun` = 0.
- Latency:
  - Word captured during phases 0–7 of group N is transferred at phase 15.
  - Its bit 15 appears on `video` in the tick after the boundary. Bits follow one per tick, for 16 ticks.
  - `de_out` rises `SYNC_DELAY` ticks after `act`. With the default of 16, the first displayed pixel is word 0 bit 15, coincident with `de_out` rising.
- No handshake back to the timer. The block never stalls; missing data is shown as 0 (white) and flagged.
- Reset released mid-line: the delay lines refill with idle values. The first boundary after reset underruns unless a load occurred first.
- `act` dropping mid-word (short line): `cnt` clears and no further transfer occurs. `shreg` keeps shifting to zero.
- Idle: with no ticks, all state holds.

## Test plan
- Single line: 512 active ticks, words 0x8001, 0xFFFF, 0x0000, … loaded at phases 0–7 → after `de_out` rises, `video` (INVERT = 1) reads 0, then 1 ×14, then 0, then 0 ×16, then 1 ×16. `underrun` stays 0.
- Sync alignment: hsync low pulse of 4 ticks → `hsync_out` low for exactly 4 ticks, starting `SYNC_DELAY` ticks later. Repeat with `SYNC_DELAY` = 1 and 32.
- Underrun: omit the load for word 5 → word-5 pixels are all 1 (white). `underrun` = 1 from that boundary until `underrun_clr`; set + clear on the same cycle leaves it 1.
- Coincident load/boundary: force `loadPixels` at phase 15 with 0xAAAA while `hold` = 0x1234 → `shreg` gets 0x1234, and the next group shows 0xAAAA with no underrun.
- Enable gaps: insert random non-tick `clk` cycles between ticks → the output sequence is identical to the gap-free run when sampled per tick.
- Reset mid-line at active tick 200 → outputs go to their reset values immediately. After release, `de_out` stays 0 for `SYNC_DELAY` ticks and the first boundary flags an underrun if no load has occurred.

Source files
------------

// File: rtl/video_shifter.sv
// Mac Plus pixel serializer: one-word hold buffer feeding an MSB-first shifter,
// with hsync, vsync and the active flag delayed to stay aligned with the pixels.
module video_shifter #(
    parameter int SYNC_DELAY = 16,
    parameter bit INVERT     = 1'b1
) (
    input  logic        clk,
    input  logic        _reset,
    input  logic        clk8_en_p,
    input  logic        clk8_en_n,
    input  logic        loadPixels,
    input  logic [15:0] dataIn,
    input  logic        _hblank,
    input  logic        _vblank,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        underrun_clr,
    output logic        video,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        de_out,
    output logic        underrun
);

    logic                  tick;
    logic                  act;
    logic                  rise;
    logic                  boundary;
    logic [3:0]            phase;

    logic [3:0]            cnt_q, cnt_d;
    logic                  act_prev_q, act_prev_d;
    logic [15:0]           hold_q, hold_d;
    logic                  hold_v_q, hold_v_d;
    logic [15:0]           shreg_q, shreg_d;
    logic                  underrun_q, underrun_d;
    logic [SYNC_DELAY-1:0] hs_q, hs_d;
    logic [SYNC_DELAY-1:0] vs_q, vs_d;
    logic [SYNC_DELAY-1:0] de_q, de_d;

    // The first active tick is phase 0 even though cnt still reads 0 from blanking.
    always_comb begin
        tick     = clk8_en_p | clk8_en_n;
        act      = _hblank & _vblank;
        rise     = act & ~act_prev_q;
        phase    = rise ? 4'd0 : cnt_q;
        boundary = tick & act & (phase == 4'hF);
    end

    // NOTE: every signal gets its hold value first so no path through this block infers a latch.
    always_comb begin
        cnt_d      = cnt_q;
        act_prev_d = act_prev_q;
        hold_d     = hold_q;
        hold_v_d   = hold_v_q;
        shreg_d    = shreg_q;
        hs_d       = hs_q;
        vs_d       = vs_q;
        de_d       = de_q;

        if (tick) begin
            act_prev_d = act;
            if (!act)     cnt_d = 4'd0;
            else if (rise) cnt_d = 4'd1;
            else          cnt_d = cnt_q + 4'd1;

            if (boundary) begin
                shreg_d  = hold_v_q ? hold_q : 16'h0000;
                hold_v_d = 1'b0;
            end else begin
                shreg_d  = {shreg_q[14:0], 1'b0};
            end

            // A load on the boundary tick lands after the transfer has taken the old word.
            if (loadPixels) begin
                hold_d   = dataIn;
                hold_v_d = 1'b1;
            end

            hs_d[0] = hsync;
            vs_d[0] = vsync;
            de_d[0] = act;
            for (int i = 1; i < SYNC_DELAY; i++) begin
                hs_d[i] = hs_q[i-1];
                vs_d[i] = vs_q[i-1];
                de_d[i] = de_q[i-1];
            end
        end
    end

    // Set beats clear; the clear acts on any clock, not just ticks.
    always_comb begin
        underrun_d = underrun_q;
        if (boundary && !hold_v_q) underrun_d = 1'b1;
        else if (underrun_clr)     underrun_d = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            cnt_q      <= 4'd0;
            act_prev_q <= 1'b0;
            hold_q     <= 16'h0000;
            hold_v_q   <= 1'b0;
            shreg_q    <= 16'h0000;
            underrun_q <= 1'b0;
            hs_q       <= '1;
            vs_q       <= '1;
            de_q       <= '0;
        end else begin
            cnt_q      <= cnt_d;
            act_prev_q <= act_prev_d;
            hold_q     <= hold_d;
            hold_v_q   <= hold_v_d;
            shreg_q    <= shreg_d;
            underrun_q <= underrun_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            de_q       <= de_d;
        end
    end

    assign hsync_out = hs_q[SYNC_DELAY-1];
    assign vsync_out = vs_q[SYNC_DELAY-1];
    assign de_out    = de_q[SYNC_DELAY-1];
    assign video     = de_out ? (shreg_q[15] ^ INVERT) : 1'b0;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_video_shifter.sv
// Bench for video_shifter: three instances (sync delay 1, 16, 32) share stimulus
// and are compared each clock against a tick-history reference model.
`timescale 1ns/1ps
module tb_video_shifter;

    localparam int NONE = -100;
    localparam logic [14:0] RST_VEC = {3{5'b01100}};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_p = 1'b0, en_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] din = 16'h0;
    logic        hb = 1'b0, vb = 1'b0, hs = 1'b1, vs = 1'b1, uclr = 1'b0;

    logic v1, hso1, vso1, de1, ur1;
    logic v16, hso16, vso16, de16, ur16;
    logic v32, hso32, vso32, de32, ur32;
    logic [14:0] got;

    video_shifter #(.SYNC_DELAY(1)) u_d1 (
        .clk(clk), ._reset(rst_n), .clk8_en_p(en_p), .clk8_en_n(en_n),
        .loadPixels(load), .dataIn(din), ._hblank(hb), ._vblank(vb),
        .hsync(hs), .vsync(vs), .underrun_clr(uclr),
        .video(v1), .hsync_out(hso1), .vsync_out(vso1), .de_out(de1), .underrun(ur1));
    video_shifter #(.SYNC_DELAY(16)) u_d16 (
        .clk(clk), ._reset(rst_n), .clk8_en_p(en_p), .clk8_en_n(en_n),
        .loadPixels(load), .dataIn(din), ._hblank(hb), ._vblank(vb),
        .hsync(hs), .vsync(vs), .underrun_clr(uclr),
        .video(v16), .hsync_out(hso16), .vsync_out(vso16), .de_out(de16), .underrun(ur16));
    video_shifter #(.SYNC_DELAY(32)) u_d32 (
        .clk(clk), ._reset(rst_n), .clk8_en_p(en_p), .clk8_en_n(en_n),
        .loadPixels(load), .dataIn(din), ._hblank(hb), ._vblank(vb),
        .hsync(hs), .vsync(vs), .underrun_clr(uclr),
        .video(v32), .hsync_out(hso32), .vsync_out(vso32), .de_out(de32), .underrun(ur32));

    assign got = {v1, hso1, vso1, de1, ur1, v16, hso16, vso16, de16, ur16,
                  v32, hso32, vso32, de32, ur32};

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: run length since act rose, plain word buffer, input histories.
    logic [15:0] m_hold, m_shreg;
    bit          m_hold_v, m_under, m_act_prev;
    int          m_run;
    bit          h_hs[$], h_vs[$], h_act[$];

    logic [15:0] words[$];
    bit          det_phases = 1'b0;
    bit [3:0]    lg16[$];
    bit          lg_hs1[$], lg_hs32[$];
    int          rst_log_idx;

    task automatic model_reset();
        m_hold = 16'h0; m_shreg = 16'h0; m_hold_v = 0; m_under = 0;
        m_act_prev = 0; m_run = 0;
        h_hs.delete(); h_vs.delete(); h_act.delete();
    endtask

    task automatic model_clock(input bit tick);
        bit a, bnd;
        a = hb & vb;
        bnd = 0;
        if (tick) begin
            if (a) m_run = m_act_prev ? m_run + 1 : 0;
            else   m_run = 0;
            bnd = a && (m_run % 16 == 15);
        end
        if (bnd && !m_hold_v) m_under = 1;
        else if (uclr)        m_under = 0;
        if (tick) begin
            if (bnd) begin
                m_shreg  = m_hold_v ? m_hold : 16'h0;
                m_hold_v = 0;
            end else begin
                m_shreg = m_shreg << 1;
            end
            if (load) begin
                m_hold = din;
                m_hold_v = 1;
            end
            m_act_prev = a;
            h_hs.push_back(hs);
            h_vs.push_back(vs);
            h_act.push_back(a);
        end
    endtask

    function automatic bit hist(input int d, input int sel);
        int n;
        n = h_act.size();
        if (n < d) return (sel == 2) ? 1'b0 : 1'b1;
        case (sel)
            0:       return h_hs[n-d];
            1:       return h_vs[n-d];
            default: return h_act[n-d];
        endcase
    endfunction

    function automatic logic [4:0] exp_for(input int d);
        bit de;
        de = hist(d, 2);
        return {de & ~m_shreg[15], hist(d, 0), hist(d, 1), de, m_under};
    endfunction

    function automatic logic [14:0] exp_all();
        return {exp_for(1), exp_for(16), exp_for(32)};
    endfunction

    task automatic step(input bit tick);
        if (tick) begin
            case ($urandom_range(2))
                0:       {en_p, en_n} = 2'b10;
                1:       {en_p, en_n} = 2'b01;
                default: {en_p, en_n} = 2'b11;
            endcase
        end else begin
            {en_p, en_n} = 2'b00;
        end
        @(posedge clk);
        if (rst_n) model_clock(tick);
        #1;
        {en_p, en_n} = 2'b00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        hb = 0; vb = 1; hs = 1; vs = 1; load = 0; uclr = 0;
        step(0);
        step(0);
        model_reset();
        rst_n = 1'b1;
        step(0);
        lg16.delete(); lg_hs1.delete(); lg_hs32.delete();
    endtask

    function automatic logic [15:0] word_for(input int g);
        if (g < words.size()) return words[g];
        return 16'($urandom);
    endfunction

    // One line: n_act active ticks then n_blank blanking ticks, compared against the model every clock.
    task automatic run_line(input int n_act, input int n_blank, input int skip_grp,
                            input int coin_grp, input int gap_max, input int rst_at,
                            input int hs_at, input int clr_at, input string tag);
        int  ld_ph;
        bit  no_load;
        ld_ph = 0;
        no_load = 0;
        for (int i = 0; i < n_act + n_blank; i++) begin
            bit active;
            int bi, g, ph, ng;
            active = (i < n_act);
            bi = i - n_act;
            g  = i / 16;
            ph = i % 16;
            ng = (gap_max > 0) ? $urandom_range(gap_max) : 0;
            for (int k = 0; k < ng; k++) begin
                load = 1'($urandom); din = 16'($urandom); hb = 1'($urandom);
                vb = 1'($urandom); hs = 1'($urandom); vs = 1'($urandom);
                step(0);
                checks++;
                if (got !== exp_all()) begin
                    failures++;
                    $display("FAIL %s gap tick=%0d outputs got=%h exp=%h", tag, i, got, exp_all());
                end
            end
            if (active && i == rst_at) begin
                rst_n = 1'b0;
                #1;
                checks++;
                if (got !== RST_VEC) begin
                    failures++;
                    $display("FAIL %s async reset outputs got=%h exp=%h", tag, got, RST_VEC);
                end
                model_reset();
                step(1);
                step(1);
                checks++;
                if (got !== RST_VEC) begin
                    failures++;
                    $display("FAIL %s held reset outputs got=%h exp=%h", tag, got, RST_VEC);
                end
                rst_n = 1'b1;
                no_load = 1;
                rst_log_idx = lg16.size();
            end
            if (ph == 0) ld_ph = det_phases ? (g % 8) : $urandom_range(7);
            hb = active;
            vb = 1'b1;
            hs = !(hs_at >= 0 && !active && bi >= hs_at && bi < hs_at + 4);
            vs = !(hs_at >= 0 && !active && bi >= hs_at + 10 && bi < hs_at + 16);
            load = 0;
            din = 16'($urandom);
            if (active && !no_load) begin
                if (g == coin_grp) begin
                    if (ph == ld_ph) begin load = 1; din = 16'h1234; end
                    else if (ph == 15) begin load = 1; din = 16'hAAAA; end
                end else if (g != skip_grp && g != coin_grp + 1 && ph == ld_ph) begin
                    load = 1;
                    din = word_for(g);
                end
            end
            uclr = (active && i == clr_at);
            step(1);
            uclr = 0;
            checks++;
            if (got !== exp_all()) begin
                failures++;
                $display("FAIL %s tick=%0d outputs got=%h exp=%h", tag, i, got, exp_all());
            end
            lg16.push_back({v16, hso16, vso16, de16});
            lg_hs1.push_back(hso1);
            lg_hs32.push_back(hso32);
        end
        load = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 6; k++) begin
            load = 1'($urandom); din = 16'($urandom); hb = 1'($urandom);
            vb = 1'($urandom); hs = 1'($urandom); vs = 1'($urandom);
            step(k % 2 == 0);
            checks++;
            if (got !== RST_VEC) begin
                failures++;
                $display("FAIL reset_state got=%h exp=%h", got, RST_VEC);
            end
        end
        do_reset();
        checks++;
        if (got !== exp_all()) begin
            failures++;
            $display("FAIL reset_release got=%h exp=%h", got, exp_all());
        end
    endtask

    task automatic test_single_line();
        int first_de;
        logic [15:0] seq, w;
        logic [15:0] pat[3];
        pat[0] = 16'h8001; pat[1] = 16'hFFFF; pat[2] = 16'h0000;
        do_reset();
        words.delete();
        for (int k = 0; k < 3; k++) words.push_back(pat[k]);
        run_line(512, 64, NONE, NONE, 0, NONE, NONE, NONE, "single_line");
        first_de = -1;
        for (int k = 0; k < lg16.size(); k++)
            if (first_de < 0 && lg16[k][0]) first_de = k;
        checks++;
        if (first_de !== 15) begin
            failures++;
            $display("FAIL de_rise_tick got=%0d exp=15", first_de);
        end
        if (first_de < 0) first_de = 0;
        for (int k = 0; k < 3; k++) begin
            w = pat[k];
            for (int b = 0; b < 16; b++) seq[15-b] = lg16[first_de + 16*k + b][3];
            checks++;
            if (seq !== ~w) begin
                failures++;
                $display("FAIL word%0d_pixels got=%h exp=%h", k, seq, ~w);
            end
        end
        checks++;
        if (ur16 !== 1'b0) begin
            failures++;
            $display("FAIL single_line_underrun got=%b exp=0", ur16);
        end
    endtask

    task automatic test_sync();
        int first[3], len[3], expf[3];
        do_reset();
        words.delete();
        run_line(64, 80, NONE, NONE, 0, NONE, 10, NONE, "sync");
        expf[0] = 74; expf[1] = 74 + 15; expf[2] = 74 + 31;
        for (int d = 0; d < 3; d++) begin
            first[d] = -1;
            len[d] = 0;
            for (int k = 0; k < lg16.size(); k++) begin
                bit s;
                s = (d == 0) ? lg_hs1[k] : (d == 1) ? lg16[k][2] : lg_hs32[k];
                if (!s) begin
                    if (first[d] < 0) first[d] = k;
                    len[d]++;
                end
            end
            checks++;
            if (first[d] != expf[d] || len[d] != 4) begin
                failures++;
                $display("FAIL hsync_align_%0d start got=%0d exp=%0d len got=%0d exp=4",
                         d, first[d], expf[d], len[d]);
            end
        end
    endtask

    task automatic test_underrun();
        logic [15:0] seq;
        do_reset();
        words.delete();
        run_line(256, 32, 5, NONE, 0, NONE, NONE, NONE, "underrun");
        for (int b = 0; b < 16; b++) seq[15-b] = lg16[95 + b][3];
        checks++;
        if (seq !== 16'hFFFF) begin
            failures++;
            $display("FAIL underrun_white got=%h exp=ffff", seq);
        end
        checks++;
        if ({ur1, ur16, ur32} !== 3'b111) begin
            failures++;
            $display("FAIL underrun_sticky got=%b exp=111", {ur1, ur16, ur32});
        end
        uclr = 1; step(0); uclr = 0;
        checks++;
        if ({ur1, ur16, ur32} !== 3'b000) begin
            failures++;
            $display("FAIL underrun_clear got=%b exp=000", {ur1, ur16, ur32});
        end
        run_line(64, 16, 2, NONE, 0, NONE, NONE, 47, "set_and_clear");
        checks++;
        if (ur16 !== 1'b1) begin
            failures++;
            $display("FAIL set_beats_clear got=%b exp=1", ur16);
        end
        uclr = 1; step(0); uclr = 0;
        checks++;
        if (ur16 !== 1'b0) begin
            failures++;
            $display("FAIL underrun_clear2 got=%b exp=0", ur16);
        end
    endtask

    task automatic test_coincident();
        logic [15:0] s3, s4;
        do_reset();
        words.delete();
        run_line(128, 32, NONE, 3, 0, NONE, NONE, NONE, "coincident");
        for (int b = 0; b < 16; b++) begin
            s3[15-b] = lg16[63 + b][3];
            s4[15-b] = lg16[79 + b][3];
        end
        checks++;
        if (s3 !== ~16'h1234 || s4 !== ~16'hAAAA) begin
            failures++;
            $display("FAIL coincident_words got=%h,%h exp=%h,%h", s3, s4, ~16'h1234, ~16'hAAAA);
        end
        checks++;
        if (ur16 !== 1'b0) begin
            failures++;
            $display("FAIL coincident_underrun got=%b exp=0", ur16);
        end
    endtask

    task automatic test_gaps();
        bit [3:0] ref_log[$];
        do_reset();
        words.delete();
        for (int k = 0; k < 32; k++) words.push_back(16'($urandom));
        det_phases = 1;
        run_line(512, 40, NONE, NONE, 0, NONE, 5, NONE, "no_gaps");
        ref_log = lg16;
        do_reset();
        run_line(512, 40, NONE, NONE, 3, NONE, 5, NONE, "gaps");
        det_phases = 0;
        checks++;
        if (lg16.size() != ref_log.size()) begin
            failures++;
            $display("FAIL gap_log_len got=%0d exp=%0d", lg16.size(), ref_log.size());
        end else begin
            for (int k = 0; k < lg16.size(); k++) begin
                checks++;
                if (lg16[k] !== ref_log[k]) begin
                    failures++;
                    $display("FAIL gap_equiv tick=%0d got=%h exp=%h", k, lg16[k], ref_log[k]);
                end
            end
        end
    endtask

    task automatic test_reset_midline();
        int zeros;
        do_reset();
        words.delete();
        run_line(400, 40, NONE, NONE, 0, 200, NONE, NONE, "reset_midline");
        zeros = 0;
        while (zeros < 40 && rst_log_idx + zeros < lg16.size() && !lg16[rst_log_idx + zeros][0])
            zeros++;
        checks++;
        if (zeros != 15) begin
            failures++;
            $display("FAIL post_reset_de_zero_ticks got=%0d exp=15", zeros);
        end
        checks++;
        if (ur16 !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_underrun got=%b exp=1", ur16);
        end
    endtask

    initial begin
        model_reset();
        #2;
        test_reset();
        test_single_line();
        test_sync();
        test_underrun();
        test_coincident();
        test_gaps();
        test_reset_midline();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
